// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low glyph patterns {g,f,e,d,c,b,a},
// scan-decoder FSM state encoding and the fixed digit count.
`timescale 1ns/1ps
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned CODE_W     = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef logic [1:0] scan_state_t;

  localparam scan_state_t ST_WAIT   = 2'd0;
  localparam scan_state_t ST_ACCEPT = 2'd1;
  localparam scan_state_t ST_HOLD   = 2'd2;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational lookup from an active-low segment pattern to its hex code.
`timescale 1ns/1ps
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0]  pattern,
  output logic [CODE_W-1:0] code_c,
  output logic              blank_c,
  output logic              valid_c
);

  always_comb begin
    code_c  = '0;
    blank_c = 1'b0;
    valid_c = 1'b1;
    case (pattern)
      SEG_0:     code_c = 4'h0;
      SEG_1:     code_c = 4'h1;
      SEG_2:     code_c = 4'h2;
      SEG_3:     code_c = 4'h3;
      SEG_4:     code_c = 4'h4;
      SEG_5:     code_c = 4'h5;
      SEG_6:     code_c = 4'h6;
      SEG_7:     code_c = 4'h7;
      SEG_8:     code_c = 4'h8;
      SEG_9:     code_c = 4'h9;
      SEG_A:     code_c = 4'hA;
      SEG_B:     code_c = 4'hB;
      SEG_C:     code_c = 4'hC;
      SEG_D:     code_c = 4'hD;
      SEG_E:     code_c = 4'hE;
      SEG_F:     code_c = 4'hF;
      SEG_BLANK: blank_c = 1'b1;
      default:   valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Readback receiver for the multiplexed 7-segment bus: debounces each anode
// dwell, decodes it, and assembles 8-digit frames. Define SEG_SCAN_ERRCNT_EN
// to add the saturating err_count output.
`timescale 1ns/1ps
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              segment,
  input  logic [NUM_DIGITS-1:0]   AN,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_lit,
  output logic                    frame_done,
  output logic                    bad_an,
  output logic                    bad_glyph
`ifdef SEG_SCAN_ERRCNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  import seg_pkg::*;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SLOT_W = $clog2(NUM_DIGITS);
  localparam int unsigned ZW     = $clog2(NUM_DIGITS + 1);
  localparam int unsigned DIG_W  = CODE_W * NUM_DIGITS;
  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);

  logic [SEG_W-1:0]      seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [CNT_W-1:0]      cnt, cnt_next;
  scan_state_t           state, state_next;
  logic [DIG_W-1:0]      shadow, shadow_next;
  logic [NUM_DIGITS-1:0] shadow_lit, lit_next;
  logic [NUM_DIGITS-1:0] seen, seen_next;

  logic                  stable_c, accept_c, capture_c, an_legal_c, frame_full_c;
  logic [ZW-1:0]         an_zeros;
  logic [SLOT_W-1:0]     slot;
  logic [CODE_W-1:0]     dec_code;
  logic                  dec_blank, dec_valid;

  seg_glyph_decode u_decode (
    .pattern (seg_q),
    .code_c  (dec_code),
    .blank_c (dec_blank),
    .valid_c (dec_valid)
  );

  // Stability counter and dwell FSM; a changing input restarts the dwell.
  always_comb begin
    stable_c   = ({segment, AN} == {seg_q, an_q});
    cnt_next   = '0;
    state_next = state;
    if (stable_c) begin
      cnt_next = (cnt >= SETTLE) ? SETTLE : cnt + CNT_W'(1);
    end
    case (state)
      ST_WAIT:   if (cnt_next == SETTLE) state_next = ST_ACCEPT;
      ST_ACCEPT: state_next = stable_c ? ST_HOLD : ST_WAIT;
      ST_HOLD:   if (!stable_c) state_next = ST_WAIT;
      default:   state_next = ST_WAIT;
    endcase
  end

  // Anode legality, slot capture into the shadow frame, and frame completion.
  always_comb begin
    an_zeros = '0;
    slot     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        an_zeros = an_zeros + ZW'(1);
        slot     = SLOT_W'(i);
      end
    end
    an_legal_c   = (an_zeros == ZW'(1));
    accept_c     = (state == ST_WAIT) && (cnt_next == SETTLE);
    capture_c    = accept_c && an_legal_c;
    frame_full_c = &seen;

    shadow_next = shadow;
    lit_next    = shadow_lit;
    seen_next   = frame_full_c ? '0 : seen;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture_c && (slot == SLOT_W'(i))) begin
        shadow_next[i*CODE_W +: CODE_W] = dec_code;
        lit_next[i]                     = dec_valid && !dec_blank;
        seen_next[i]                    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
      cnt        <= '0;
      state      <= ST_WAIT;
      shadow     <= '0;
      shadow_lit <= '0;
      seen       <= '0;
      digits     <= '0;
      digit_lit  <= '0;
      frame_done <= 1'b0;
      bad_an     <= 1'b0;
      bad_glyph  <= 1'b0;
    end else begin
      seg_q      <= segment;
      an_q       <= AN;
      cnt        <= cnt_next;
      state      <= state_next;
      shadow     <= shadow_next;
      shadow_lit <= lit_next;
      seen       <= seen_next;
      frame_done <= frame_full_c;
      bad_an     <= accept_c && !an_legal_c;
      bad_glyph  <= capture_c && !dec_valid;
      if (frame_full_c) begin
        digits    <= shadow;
        digit_lit <= shadow_lit;
      end
    end
  end

`ifdef SEG_SCAN_ERRCNT_EN
  logic err_c;
  assign err_c = accept_c && !(an_legal_c && dec_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_c && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Readback receiver for the multiplexed 7-segment bus driven by the score display block. It samples the time-multiplexed `segment`/`AN` stream, rejects transition glitches, and decodes each anode slot back into a 4-bit glyph code. It assembles complete 8-digit frames and flags malformed traffic. It sits beside the display driver as an on-chip self-check and board-level monitor, so game state (choices 0–15, lives 0–3) can be confirmed from what is actually shown.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4 — consecutive identical registered samples required before a slot is accepted; legal range 1–255.
- `NUM_DIGITS`, 8 — anode count; fixed at 8 for this design.

Ports:
- `clk` input 1 — single system clock, rising edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `segment` input 7 — cathodes `{g,f,e,d,c,b,a}`, active-low.
- `AN` input 8 — anodes, active-low; exactly one low means a legal slot.
- `digits` output 32 — last complete frame; nibble i (bits 4i+3:4i) holds the code for anode i.
- `digit_lit` output 8 — bit i is 1 if anode i showed a non-blank glyph in the last frame.
- `frame_done` output 1 — one-cycle pulse when `digits`/`digit_lit` update.
- `bad_an` output 1 — one-cycle pulse on an accepted sample with zero or ≥2 anodes low.
- `bad_glyph` output 1 — one-cycle pulse on an accepted sample whose pattern is not in the decode table.

## Operation
- Input stage: `segment` and `AN` are registered once into `seg_q` and `an_q`.
- Stability counter `cnt` (8 bits):
  - Clears to 0 when `{seg_q,an_q}` differs from the previous cycle.
  - Otherwise increments, saturating at `SETTLE_CYCLES`.
- FSM states:
  - WAIT: `cnt` below `SETTLE_CYCLES`.
  - ACCEPT: one cycle, entered when `cnt` reaches `SETTLE_CYCLES`.
  - HOLD: dwell already consumed. Return to WAIT on the next input change.
  - Each dwell is accepted at most once.
- In ACCEPT:
  - Illegal anode pattern: pulse `bad_an`; do not capture.
  - Legal slot i, with glyph in the table: write the code to shadow nibble i. Set shadow lit bit i to 1, or to 0 for blank (`7'b1111111`, code 0). Set seen-mask bit i.
  - Legal slot i, with glyph not in the table: pulse `bad_glyph`. Write code 0 and lit 0, set the seen-mask bit, and continue.
- Decode table: standard hex glyphs 0–9, A, b, C, d, E, F mapped to codes 0–15, plus blank.
- Frame completion:
  - The cycle after the seen-mask becomes 8'hFF: copy shadow to `digits`/`digit_lit`, pulse `frame_done`, clear seen-mask.
  - A re-accepted slot before completion overwrites its shadow nibble. Last value wins.
- Simultaneous events: completion and a new ACCEPT in the same cycle are both handled. The new capture lands in the freshly cleared mask and is not lost.

## Timing
- Reset values: `digits`=0, `digit_lit`=0, all pulses 0. Internal state: `cnt`=0, seen-mask=0, state WAIT.
- Input changes at edge t → `seg_q`/`an_q` update at t+1 → ACCEPT effects (pulses, shadow write) at edge t+1+`SETTLE_CYCLES`.
- `frame_done` and updated outputs appear one cycle after the eighth-slot capture. Outputs then hold until the next frame.
- Glitch rule: a dwell shorter than `SETTLE_CYCLES`+1 registered cycles is never accepted.
- Reset mid-frame: the partial shadow and mask are discarded, and the next frame starts clean.

## Configuration
- `SEG_SCAN_ERRCNT_EN` defined:
  - Adds output `err_count` (8 bits, reset 0).
  - Increments on each `bad_an` or `bad_glyph` pulse (+1 even if both fire) and saturates at 255.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `seg_pkg`:
  - Active-low glyph constants (`SEG_0`…`SEG_F`, `SEG_BLANK`).
  - FSM state typedef.
  - `NUM_DIGITS`.
  - The same constants are used by the display driver.
- One sub-module `seg_glyph_decode` (combinational): 7-bit pattern in; 4-bit code, `blank`, and `valid` out. The top level holds all sequential logic.

## Test plan
- Reset, then scan anodes 0–7 with 8 cycles per slot: slot 7 shows C (`1000110`), slot 6 shows b (`0000011`), slot 5 shows 3 (`0110000`), slot 4 shows 2 (`0100100`), the rest blank. Required: one `frame_done`, `digits`=32'hCB32_0000, `digit_lit`=8'hF0.
- Identical scan, but each slot is preceded by a 2-cycle glitch `AN`=8'h00. Required: same frame, no `bad_an`.
- Hold `AN`=8'hFC for 10 cycles. Required: exactly one `bad_an` pulse, no capture.
- Slot 3 shows `1111110`. Required: one `bad_glyph`, nibble 3 = 0, lit bit 3 = 0, frame still completes.
- Assert `rst_n` low for 1 cycle after 5 slots are captured, then run a full scan with slot 0 = d (`0100001`). Required: `frame_done` only after all 8 new slots, `digits[3:0]`=4'hD.
- With `SEG_SCAN_ERRCNT_EN`: 300 illegal dwells. Required: `err_count` = 255.
